// File: rtl/bmem_arb_pkg.sv
// Shared types for the bmem line arbiter: FSM states, owner tag and beat count.
package bmem_arb_pkg;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_BEAT, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int BEATS = 4;

endpackage

// File: rtl/bmem_line_arbiter.sv
// Round-robin arbiter sharing one 64-bit burst bmem port between I-cache and D-cache line ports.
// Each grant moves one 256-bit line as 4 beats and runs to completion before the next grant.
module bmem_line_arbiter
  import bmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_dfp_addr,
  input  logic              i_dfp_read,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic              i_dfp_resp,
  input  logic [ADDR_W-1:0] d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam logic [1:0]        LAST_BEAT  = 2'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-5){1'b1}}, 5'b0};

  arb_state_t        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;

  logic   i_req, d_req, grant_wr;
  owner_t grant;

  assign i_req    = i_dfp_read;
  assign d_req    = d_dfp_read | d_dfp_write;
  // On a tie the requester that was not served last wins.
  assign grant    = (i_req && d_req) ? ((last_q == OWN_I) ? OWN_D : OWN_I)
                                     : (d_req ? OWN_D : OWN_I);
  // A D-side read+write pair serves the writeback first; the held read re-arbitrates later.
  assign grant_wr = (grant == OWN_D) && d_dfp_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant;
          is_wr_d = grant_wr;
          addr_d  = ((grant == OWN_I) ? i_dfp_addr : d_dfp_addr) & ALIGN_MASK;
          if (grant_wr) wdata_d = d_dfp_wdata;
          state_d = grant_wr ? WR_BEAT : RD_CMD;
        end
      end
      RD_CMD: begin
        if (bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bmem_rvalid) begin
          buf_d[int'(cnt_q)*BEAT_W +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      WR_BEAT: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      owner_q <= OWN_I;
      last_q  <= OWN_D;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them immediately.
  assign bmem_read   = (state_q == RD_CMD);
  assign bmem_write  = (state_q == WR_BEAT);
  assign bmem_addr   = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata  = bmem_write ? wdata_q[int'(cnt_q)*BEAT_W +: BEAT_W] : '0;
  assign i_dfp_resp  = (state_q == RESP) && (owner_q == OWN_I);
  assign d_dfp_resp  = (state_q == RESP) && (owner_q == OWN_D);
  assign i_dfp_rdata = (owner_q == OWN_I) ? buf_q : '0;
  assign d_dfp_rdata = (owner_q == OWN_D) ? buf_q : '0;

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter: reads, paced writes, round-robin ties, stray beats, reset abort.
module tb_bmem_line_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_dfp_addr;
  logic         i_dfp_read;
  logic [255:0] i_dfp_rdata;
  logic         i_dfp_resp;
  logic [31:0]  d_dfp_addr;
  logic         d_dfp_read;
  logic         d_dfp_write;
  logic [255:0] d_dfp_wdata;
  logic [255:0] d_dfp_rdata;
  logic         d_dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int passes = 0;
  int overlap = 0;

  localparam logic [255:0] LA = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                                 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
  localparam logic [255:0] LW = {64'h5757_3333_0000_0003, 64'h5757_2222_0000_0002,
                                 64'h5757_1111_0000_0001, 64'h5757_0000_0000_0000};
  localparam logic [255:0] L1 = {4{64'h1111_2222_3333_4444}};
  localparam logic [255:0] L2 = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
  localparam logic [255:0] L3 = {64'h3C, 64'h3B, 64'h3A, 64'h39};
  localparam logic [255:0] LB = {64'hB3B3, 64'hB2B2, 64'hB1B1, 64'hB0B0};
  localparam logic [255:0] LC = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
  localparam logic [255:0] LD = {64'hE3E3, 64'hE2E2, 64'hE1E1, 64'hE0E0};

  bmem_line_arbiter dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
    .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (i_dfp_resp && d_dfp_resp) overlap++;

  // Plays the memory side of one read burst; returns addresses seen and accepted command count.
  task automatic serve_read(input logic [255:0] line, input int hold, input bit chg,
                            input logic [31:0] mid, output logic [31:0] a_first,
                            output logic [31:0] a_last, output int acc, output bit ok);
    ok = 1'b0; acc = 0; a_first = '0; a_last = '0;
    bmem_ready = (hold == 0);
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (bmem_read) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) return;
    a_first = bmem_addr;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (chg && h == 0) d_dfp_addr = mid;
      if (h == hold - 1) bmem_ready = 1'b1;
      @(negedge clk);
    end
    a_last = bmem_addr;
    if (bmem_read && bmem_ready) acc++;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = line[k*64 +: 64];
      if (chg && hold == 0 && k == 2) d_dfp_addr = mid;
      @(negedge clk);
      if (bmem_read) acc++;
      @(posedge clk); #1;
    end
    bmem_rvalid = 1'b0;
    bmem_rdata  = '0;
  endtask

  task automatic wait_resp(output bit gi, output bit gd, output bit ok);
    ok = 1'b0; gi = 1'b0; gd = 1'b0;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk);
      if (i_dfp_resp || d_dfp_resp) begin
        ok = 1'b1; gi = i_dfp_resp; gd = d_dfp_resp;
      end
    end
  endtask

  task automatic after_resp(input bit drop_i, input bit drop_d, output logic ia, output logic da);
    if (drop_i) i_dfp_read = 1'b0;
    if (drop_d) begin d_dfp_read = 1'b0; d_dfp_write = 1'b0; end
    @(negedge clk);
    ia = i_dfp_resp; da = d_dfp_resp;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if ({bmem_read, bmem_write, i_dfp_resp, d_dfp_resp} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {bmem_read, bmem_write, i_dfp_resp, d_dfp_resp}); else passes++;
    checks++; if (bmem_addr !== 32'h0 || bmem_wdata !== 64'h0) $display("FAIL reset_bus: got addr %h wdata %h want 0", bmem_addr, bmem_wdata); else passes++;
    checks++; if (i_dfp_rdata !== '0 || d_dfp_rdata !== '0) $display("FAIL reset_rdata: got %h / %h want 0", i_dfp_rdata, d_dfp_rdata); else passes++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_read_basic();
    logic [31:0] af, al; int acc; bit ok, gi, gd; logic ia, da;
    i_dfp_addr = 32'h0000_1013; i_dfp_read = 1'b1;
    serve_read(LA, 0, 1'b0, 32'h0, af, al, acc, ok);
    checks++; if (!ok || af !== 32'h1000) $display("FAIL rd_addr: got %h (seen %0d) want 00001000", af, ok); else passes++;
    checks++; if (acc !== 1) $display("FAIL rd_cmd_count: got %0d want 1", acc); else passes++;
    wait_resp(gi, gd, ok);
    checks++; if (!ok || !gi || gd) $display("FAIL rd_resp: got i=%0d d=%0d want i=1 d=0", gi, gd); else passes++;
    checks++; if (i_dfp_rdata !== LA) $display("FAIL rd_data: got %h want %h", i_dfp_rdata, LA); else passes++;
    checks++; if (d_dfp_rdata !== '0) $display("FAIL rd_nonowner_data: got %h want 0", d_dfp_rdata); else passes++;
    after_resp(1'b1, 1'b0, ia, da);
    checks++; if (ia !== 1'b0) $display("FAIL rd_resp_width: got %b want 0", ia); else passes++;
  endtask

  task automatic test_write_paced();
    bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] acc[8]; int n_acc = 0; int last_acc = -1; int resp_cyc = -1;
    int pidx = 0; int addr_bad = 0; logic ia, da;
    d_dfp_addr = 32'h0000_2020; d_dfp_wdata = LW; d_dfp_write = 1'b1; bmem_ready = 1'b0;
    for (int c = 0; c < 16 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (d_dfp_resp) resp_cyc = c;
      else begin
        if (bmem_write) begin
          if (bmem_addr !== 32'h2020) addr_bad++;
          if (bmem_ready && n_acc < 8) begin acc[n_acc] = bmem_wdata; n_acc++; last_acc = c; end
        end
        @(posedge clk); #1;
        if (bmem_write) begin bmem_ready = (pidx < 6) ? pat[pidx] : 1'b1; pidx++; end
        else bmem_ready = 1'b0;
      end
    end
    checks++; if (n_acc !== 4) $display("FAIL wr_beat_count: got %0d want 4", n_acc); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++; if (acc[k] !== LW[k*64 +: 64]) $display("FAIL wr_beat%0d: got %h want %h", k, acc[k], LW[k*64 +: 64]); else passes++;
    end
    checks++; if (addr_bad !== 0) $display("FAIL wr_addr_hold: got %0d bad cycles want 0", addr_bad); else passes++;
    checks++; if (resp_cyc < 0 || resp_cyc !== last_acc + 1) $display("FAIL wr_resp_timing: got cycle %0d want %0d", resp_cyc, last_acc + 1); else passes++;
    after_resp(1'b0, 1'b1, ia, da);
    checks++; if (da !== 1'b0) $display("FAIL wr_resp_width: got %b want 0", da); else passes++;
  endtask

  task automatic test_tie();
    logic [31:0] af, al; int acc; bit ok, gi, gd; logic ia, da;
    do_reset();
    @(posedge clk); #1;
    i_dfp_addr = 32'h4000; i_dfp_read = 1'b1;
    d_dfp_addr = 32'h4400; d_dfp_read = 1'b1;
    serve_read(L1, 0, 1'b0, 32'h0, af, al, acc, ok);
    wait_resp(gi, gd, ok);
    checks++; if (af !== 32'h4000 || !gi || gd) $display("FAIL tie1_owner: got addr %h i=%0d d=%0d want 00004000 i=1", af, gi, gd); else passes++;
    checks++; if (i_dfp_rdata !== L1) $display("FAIL tie1_data: got %h want %h", i_dfp_rdata, L1); else passes++;
    after_resp(1'b0, 1'b0, ia, da);
    serve_read(L2, 0, 1'b0, 32'h0, af, al, acc, ok);
    wait_resp(gi, gd, ok);
    checks++; if (af !== 32'h4400 || gi || !gd) $display("FAIL tie2_owner: got addr %h i=%0d d=%0d want 00004400 d=1", af, gi, gd); else passes++;
    checks++; if (d_dfp_rdata !== L2 || i_dfp_rdata !== '0) $display("FAIL tie2_data: got d %h i %h want %h / 0", d_dfp_rdata, i_dfp_rdata, L2); else passes++;
    after_resp(1'b0, 1'b1, ia, da);
    serve_read(L3, 0, 1'b0, 32'h0, af, al, acc, ok);
    wait_resp(gi, gd, ok);
    checks++; if (af !== 32'h4000 || !gi || gd) $display("FAIL tie3_owner: got addr %h i=%0d d=%0d want 00004000 i=1", af, gi, gd); else passes++;
    after_resp(1'b1, 1'b0, ia, da);
  endtask

  task automatic test_stray_rvalid();
    logic [31:0] af, al; int acc; bit ok, gi, gd; int stray = 0;
    i_dfp_addr = 32'hA000; i_dfp_read = 1'b1;
    serve_read(LB, 0, 1'b0, 32'h0, af, al, acc, ok);
    wait_resp(gi, gd, ok);
    checks++; if (!ok || !gi) $display("FAIL stray_setup_resp: got %0d want 1", gi); else passes++;
    bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD; i_dfp_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (i_dfp_resp || d_dfp_resp || bmem_read) stray++;
    end
    bmem_rvalid = 1'b0; bmem_rdata = '0;
    checks++; if (stray !== 0) $display("FAIL stray_resp: got %0d active cycles want 0", stray); else passes++;
    checks++; if (i_dfp_rdata !== LB) $display("FAIL stray_buf: got %h want %h", i_dfp_rdata, LB); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    int lat = -1; int stray = 0; logic ia, da;
    d_dfp_addr = 32'h6000; d_dfp_wdata = LW; d_dfp_write = 1'b1; bmem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (!bmem_write || bmem_wdata !== LW[127:64]) $display("FAIL rstm_beat2: got wr=%b data %h want 1 %h", bmem_write, bmem_wdata, LW[127:64]); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++; if ({bmem_write, bmem_read, d_dfp_resp, i_dfp_resp} !== 4'b0 || bmem_addr !== 32'h0 || bmem_wdata !== 64'h0) $display("FAIL rstm_outputs: got ctrl %b addr %h data %h want 0", {bmem_write, bmem_read, d_dfp_resp, i_dfp_resp}, bmem_addr, bmem_wdata); else passes++;
    d_dfp_write = 1'b0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (d_dfp_resp || i_dfp_resp) stray++; end
    @(posedge clk); #1 rst = 1'b1;
    checks++; if (stray !== 0 || bmem_write !== 1'b0) $display("FAIL rstm_no_resp: got %0d resp cycles, wr=%b want 0", stray, bmem_write); else passes++;
    d_dfp_addr = 32'h7000; d_dfp_write = 1'b1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      if (d_dfp_resp) lat = k; else begin @(posedge clk); #1; end
    end
    checks++; if (lat !== 6) $display("FAIL rstm_next_latency: got %0d want 6", lat); else passes++;
    after_resp(1'b0, 1'b1, ia, da);
  endtask

  task automatic test_addr_change();
    logic [31:0] af, al; int acc; bit ok, gi, gd; logic ia, da;
    i_dfp_addr = 32'h8000; i_dfp_read = 1'b1;
    d_dfp_addr = 32'h9040; d_dfp_read = 1'b1;
    serve_read(LC, 0, 1'b1, 32'h90A0, af, al, acc, ok);
    wait_resp(gi, gd, ok);
    checks++; if (af !== 32'h8000 || !gi || gd) $display("FAIL chg_first: got addr %h i=%0d d=%0d want 00008000 i=1", af, gi, gd); else passes++;
    after_resp(1'b1, 1'b0, ia, da);
    serve_read(LD, 2, 1'b1, 32'h1234_5600, af, al, acc, ok);
    checks++; if (af !== 32'h90A0 || al !== 32'h90A0) $display("FAIL chg_d_addr: got %h then %h want 000090a0", af, al); else passes++;
    checks++; if (acc !== 1) $display("FAIL chg_cmd_count: got %0d want 1", acc); else passes++;
    wait_resp(gi, gd, ok);
    checks++; if (!ok || !gd || d_dfp_rdata !== LD) $display("FAIL chg_d_resp: got d=%0d data %h want 1 %h", gd, d_dfp_rdata, LD); else passes++;
    after_resp(1'b0, 1'b1, ia, da);
    checks++; if (overlap !== 0) $display("FAIL resp_overlap: got %0d cycles want 0", overlap); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    i_dfp_addr = '0; i_dfp_read = 1'b0;
    d_dfp_addr = '0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    test_reset();
    test_read_basic();
    test_write_paced();
    test_tie();
    test_stray_rvalid();
    test_reset_mid_burst();
    test_addr_change();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
